// File: rtl/sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// sram_responder_pkg
// Shared definitions for the SLC-3 SRAM responder: bus widths, lane geometry,
// the responder state type and the program image loaded after reset.
// -----------------------------------------------------------------------------
package sram_responder_pkg;

    localparam int unsigned ADDR_W    = 20;               // CPU word-address width
    localparam int unsigned DATA_W    = 16;               // SRAM word width
    localparam int unsigned LANE_W    = 8;                // one byte lane
    localparam int unsigned NUM_LANES = DATA_W / LANE_W;  // lane 1 = [15:8], lane 0 = [7:0]

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        READ_WAIT,
        READ_DRIVE
    } resp_state_t;

    // Program image copied into the array after every reset. Words beyond the
    // image read as zero.
    function automatic logic [DATA_W-1:0] init_word(input int unsigned addr);
        logic [DATA_W-1:0] w;
        case (addr)
            0:  w = 16'h5020;  // AND R0,R0,#0
            1:  w = 16'h5260;  // AND R1,R1,#0
            2:  w = 16'h1225;  // ADD R1,R0,#5
            3:  w = 16'h2C0C;  // LD  R6,#12
            4:  w = 16'h1021;  // ADD R0,R0,#1
            5:  w = 16'h14A1;  // ADD R2,R2,#1
            6:  w = 16'h927F;  // NOT R1,R1
            7:  w = 16'h0BFC;  // BRnp #-4
            8:  w = 16'h3C09;  // ST  R6,#9
            9:  w = 16'h6D81;  // LDR R6,R6,#1
            10: w = 16'h7D82;  // STR R6,R6,#2
            11: w = 16'hC1C0;  // RET
            12: w = 16'h4802;  // JSR #2
            13: w = 16'hE404;  // LEA R2,#4
            14: w = 16'hA203;  // LDI R1,#3
            15: w = 16'hB405;  // STI R2,#5
            16: w = 16'h0E01;  // BRnzp #1
            17: w = 16'hF025;  // TRAP x25
            18: w = 16'h1DBF;  // ADD R6,R6,#-1
            19: w = 16'h56E0;  // AND R3,R3,#0
            20: w = 16'h3A7C;  // data word
            21: w = 16'h9C3D;  // data word
            22: w = 16'hC0DF;  // data word
            23: w = 16'hD1E2;  // data word
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// -----------------------------------------------------------------------------
// sram_responder_if
// CPU-to-SRAM strobe/address group. All strobes are active low.
//   CE   chip enable          UB  upper-byte lane enable [15:8]
//   OE   output enable        LB  lower-byte lane enable [7:0]
//   WE   write enable         ADDR word address
// The shared Data bus is a resolved net with drivers on both sides, so it is
// wired as a plain inout port next to this interface rather than inside it.
// -----------------------------------------------------------------------------
interface sram_responder_if;
    import sram_responder_pkg::*;

    logic              CE;
    logic              UB;
    logic              LB;
    logic              OE;
    logic              WE;
    logic [ADDR_W-1:0] ADDR;

    modport master (output CE, UB, LB, OE, WE, ADDR);
    modport slave  (input  CE, UB, LB, OE, WE, ADDR);

endinterface

// File: rtl/sram_responder_byte_lane_ram.sv
// -----------------------------------------------------------------------------
// byte_lane_ram
// Single-port word array with one write enable per byte lane.
//   clk    write clock (rising edge)
//   addr   word index, shared by read and write
//   wdata  write word; only lanes with be set are stored
//   be     per-lane write enables, bit 1 = [15:8], bit 0 = [7:0]
//   rdata  combinational read of mem[addr]
// -----------------------------------------------------------------------------
module byte_lane_ram
    import sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [NUM_LANES-1:0] be,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    // NOTE: the array has no reset; contents are defined by the INIT load, and
    // a reset branch here would stop it mapping onto block RAM.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (be[l]) begin
                mem[addr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
// Memory-side end of the SLC-3 SRAM bus. After reset it copies the program
// image into its array (INIT), raises Ready, then serves CPU reads and writes.
//   Clk    single clock, rising edge
//   Reset  synchronous, active high
//   bus    CE/UB/LB/OE/WE/ADDR strobes from the CPU (slave modport)
//   Data   shared 16-bit bus; driven only while presenting read data
//   Ready  high once the image load has completed
// Parameters:
//   ADDR_BITS  depth = 2**ADDR_BITS words; higher ADDR bits alias
//   READ_LAT   cycles from read accept edge to Data driven (1..3)
// -----------------------------------------------------------------------------
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_responder_if.slave   bus,
    inout  wire  [DATA_W-1:0] Data,
    output logic              Ready
);

    localparam int unsigned LAT_W = 2;

    resp_state_t           state;
    logic [ADDR_BITS-1:0]  init_cnt;
    logic [ADDR_BITS-1:0]  lat_idx;
    logic [LAT_W-1:0]      lat_cnt;

    logic [ADDR_BITS-1:0]  idx;
    logic [NUM_LANES-1:0]  lane_en;
    logic                  wr_req;
    logic                  rd_req;
    logic                  drive_ok;

    logic [ADDR_BITS-1:0]  ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [NUM_LANES-1:0]  ram_be;
    logic [DATA_W-1:0]     rd_word;

    // Upper address bits are deliberately ignored so the array aliases.
    logic addr_unused;
    assign addr_unused = ^bus.ADDR[ADDR_W-1:ADDR_BITS];

    assign idx     = bus.ADDR[ADDR_BITS-1:0];
    assign lane_en = ~{bus.UB, bus.LB};
    assign wr_req  = !bus.CE && !bus.WE;              // WE wins over OE
    assign rd_req  = !bus.CE &&  bus.WE && !bus.OE;

    // Read data goes out only while the CPU still holds the same read; any
    // strobe change or a write releases the bus in the same cycle.
    assign drive_ok = (state == READ_DRIVE) && rd_req && (idx == lat_idx);

    assign Data[15:8] = (drive_ok && lane_en[1]) ? rd_word[15:8] : 8'hzz;
    assign Data[7:0]  = (drive_ok && lane_en[0]) ? rd_word[7:0]  : 8'hzz;

    // Array port steering. Writes come from the image during INIT, otherwise
    // from the CPU; reads after accept use the latched index.
    // NOTE: every output gets a default before the case so no path leaves a
    // value held, which would infer a latch.
    always_comb begin
        ram_addr  = idx;
        ram_wdata = Data;   // responder never drives Data while WE=0
        ram_be    = '0;
        unique case (state)
            INIT: begin
                ram_addr  = init_cnt;
                ram_wdata = init_word(32'(init_cnt));
                ram_be    = '1;
            end
            IDLE: begin
                if (wr_req) ram_be = lane_en;
            end
            READ_WAIT: begin
                ram_addr = lat_idx;
            end
            READ_DRIVE: begin
                if (wr_req) ram_be   = lane_en;
                else        ram_addr = lat_idx;
            end
            default: ;
        endcase
        // A reset edge aborts whatever write was in progress.
        if (Reset) ram_be = '0;
    end

    byte_lane_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (Clk),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .be    (ram_be),
        .rdata (rd_word)
    );

    // NOTE: all state here is sequential, so only non-blocking assignments;
    // blocking ones would make results depend on evaluation order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= INIT;
            init_cnt <= '0;
            lat_idx  <= '0;
            lat_cnt  <= '0;
            Ready    <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    init_cnt <= init_cnt + ADDR_BITS'(1);
                    // Ready rises on the edge that stores the last word.
                    if (init_cnt == '1) begin
                        Ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (rd_req) begin
                        state   <= READ_WAIT;
                        lat_idx <= idx;
                        lat_cnt <= LAT_W'(1);
                    end
                end
                READ_WAIT: begin
                    if (lat_cnt == LAT_W'(READ_LAT)) state   <= READ_DRIVE;
                    else                             lat_cnt <= lat_cnt + LAT_W'(1);
                end
                READ_DRIVE: begin
                    if (wr_req || !rd_req) begin
                        state <= IDLE;
                    end else if (idx != lat_idx) begin
                        // New address under held strobes restarts the latency.
                        state   <= READ_WAIT;
                        lat_idx <= idx;
                        lat_cnt <= LAT_W'(1);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
